// File: rtl/pulse_shaper_if.sv
// pulse_shaper_if: trigger inputs, pulse configuration and shaped outputs of pulse_shaper.
interface pulse_shaper_if #(
    parameter int CHANNELS = 4,
    parameter int HOLD_W   = 4
);
    logic [CHANNELS-1:0] in_signal;
    logic [HOLD_W-1:0]   hold_len;
    logic                retrig;
    logic [CHANNELS-1:0] new_start;
    logic                busy;

    modport master (output in_signal, hold_len, retrig, input new_start, busy);
    modport slave  (input in_signal, hold_len, retrig, output new_start, busy);
endinterface

// File: rtl/pulse_shaper.sv
// pulse_shaper: per-channel rising-edge triggered pulse stretcher, one-shot or retriggerable.
// Define PULSE_SHAPER_SYNC_EN to add a two-flop input synchroniser (+2 cycles latency).
module pulse_shaper #(
    parameter int CHANNELS = 4,
    parameter int HOLD_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pulse_shaper_if.slave     bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t              st  [CHANNELS];
    logic [HOLD_W-1:0]   cnt [CHANNELS];
    logic [HOLD_W-1:0]   len_eff;
    logic [CHANNELS-1:0] din, prev_in, trig, nxt_hold;

`ifdef PULSE_SHAPER_SYNC_EN
    logic [CHANNELS-1:0] sync1, sync2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.in_signal;
            sync2 <= sync1;
        end
    end
    assign din = sync2;
`else
    assign din = bus.in_signal;
`endif

    assign len_eff = (bus.hold_len == '0) ? HOLD_W'(1) : bus.hold_len;
    assign trig    = din & ~prev_in;

    // A channel stays in HOLD while counting, or when a retrigger lands, even in its last cycle.
    always_comb begin
        nxt_hold = '0;
        for (int i = 0; i < CHANNELS; i++)
            nxt_hold[i] = (st[i] == IDLE) ? trig[i]
                        : ((trig[i] && bus.retrig) || cnt[i] != HOLD_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                st[i]  <= IDLE;
                cnt[i] <= '0;
            end
            prev_in       <= '0;
            bus.new_start <= '0;
            bus.busy      <= 1'b0;
        end else begin
            prev_in <= din;
            for (int i = 0; i < CHANNELS; i++) begin
                if (st[i] == IDLE) begin
                    if (trig[i]) begin
                        st[i]  <= HOLD;
                        cnt[i] <= len_eff;
                    end
                end else if (trig[i] && bus.retrig) begin
                    cnt[i] <= len_eff;
                end else if (cnt[i] == HOLD_W'(1)) begin
                    st[i]  <= IDLE;
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] - HOLD_W'(1);
                end
            end
            bus.new_start <= nxt_hold;
            bus.busy      <= |nxt_hold;
        end
    end
endmodule

// File: doc/pulse_shaper.md
PULSE_SHAPER -- requirements
Module: pulse_shaper

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, giving the number of independent pulse channels (1..16).
REQ-002 The block SHALL have parameter HOLD_W, default 4, giving the width of the pulse-length field and the per-channel counter.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_signal  input  CHANNELS  trigger level per channel.
REQ-006 The block SHALL have port hold_len  input  HOLD_W  requested pulse length in cycles, shared by all channels.
REQ-007 The block SHALL have port retrig  input  1  0 = one-shot, 1 = retriggerable.
REQ-008 The block SHALL have port new_start  output  CHANNELS  shaped pulse per channel, registered.
REQ-009 The block SHALL have port busy  output  1  OR of all channels in HOLD, registered.

Function
REQ-010 Each channel SHALL register in_signal into prev_in and detect a trigger when in_signal=1 and prev_in=0 (rising edge only; a held-high level SHALL NOT retrigger).
REQ-011 Each channel SHALL be a two-state FSM: IDLE (new_start=0) and HOLD (new_start=1).
REQ-012 IDLE->HOLD SHALL occur on the clock edge that samples a trigger; new_start SHALL be 1 from that edge, i.e. one cycle of latency from trigger sample to output.
REQ-013 On entry to HOLD the channel SHALL capture len = hold_len, with 0 treated as 1; hold_len changes during HOLD SHALL NOT affect the running pulse.
REQ-014 new_start SHALL remain high for exactly len cycles, then HOLD->IDLE with new_start=0 on the following cycle.
REQ-015 With retrig=0, triggers in HOLD SHALL be ignored.
REQ-016 With retrig=1, a trigger in HOLD SHALL reload the counter with the current hold_len, so new_start stays high for len cycles counted from that trigger edge, with no low gap.
REQ-017 A trigger sampled in the final HOLD cycle SHALL act as a retrigger if retrig=1; if retrig=0 it SHALL be lost, and the channel SHALL go IDLE.
REQ-018 Channels SHALL be fully independent; simultaneous triggers on several channels SHALL each produce their own pulse.
REQ-019 busy SHALL equal the OR of the channel HOLD states, registered alongside new_start (same cycle alignment).
REQ-020 The counter SHALL decrement without wrap; hold_len = 2^HOLD_W - 1 SHALL give a pulse of that exact length.

Reset
REQ-021 rst_n=0 SHALL immediately force new_start=0, busy=0, all FSMs to IDLE, counters to 0 and prev_in to 0.
REQ-022 Reset asserted mid-pulse SHALL abort the pulse; a level still high at reset release SHALL be treated as a trigger on the first clock edge (prev_in=0).

Configuration
REQ-023 With macro PULSE_SHAPER_SYNC_EN defined, each in_signal bit SHALL pass through a two-flop synchroniser (reset to 0) ahead of edge detection, adding 2 cycles of trigger-to-output latency.
REQ-024 Without PULSE_SHAPER_SYNC_EN, in_signal SHALL feed edge detection directly, and latency SHALL be as in REQ-012.

Verification
REQ-025 Bench: ch0 in_signal high at cycle 10 and held, hold_len=3, retrig=0 -> new_start[0] high cycles 11-13 only, busy high over the same cycles.
REQ-026 Bench: hold_len=0, single-cycle trigger on ch1 -> new_start[1] high exactly 1 cycle.
REQ-027 Bench: hold_len=5, retrig=1, ch2 edges at cycles 20 and 23 -> new_start[2] high continuously cycles 21-28; with retrig=0 the result is cycles 21-25.
REQ-028 Bench: all 4 channels triggered in the same cycle with hold_len=15 -> all new_start high for 15 cycles in parallel; hold_len changed to 2 at cycle +3 does not shorten the pulses.
REQ-029 Bench: rst_n low at the 2nd cycle of a 6-cycle pulse -> new_start and busy go 0 without waiting for a clock; in_signal held high through release -> pulse restarts one cycle after the first post-reset edge.
REQ-030 Bench: REQ-025 rerun with PULSE_SHAPER_SYNC_EN defined -> same waveform shifted by 2 cycles (cycles 13-15).
